// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
// Purpose : Fetch-to-decode handshake bundle. The fetch stage drives the held
//           instruction word, its PC and a valid flag. The decode stage
//           answers with ready. A word moves downstream on every cycle where
//           valid and ready are both high.
// Signals :
//   instr_out    fetch -> decode   held instruction word
//   pc_out       fetch -> decode   PC of instr_out
//   instr_valid  fetch -> decode   instr_out holds a live word
//   instr_ready  decode -> fetch   decode accepts instr_out this cycle
// Modports: master = fetch side, slave = decode side
// ---------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int WORD_W = 20
);
    logic [WORD_W-1:0] instr_out;
    logic [WORD_W-1:0] pc_out;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output instr_out,
        output pc_out,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr_out,
        input  pc_out,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Purpose : PC and fetch stage that sits in front of instruction decode. It
//           indexes a 32-word instruction memory with the PC and keeps the
//           fetched word in a one-entry output register. It offers that word
//           to decode over a valid/ready handshake. It supports redirects and
//           stops after a HALT opcode has been handed over.
// Ports   :
//   clk             rising-edge clock
//   reset           synchronous, active-high; overrides every other input
//   start           leave IDLE/HALTED and fetch from RESET_PC
//   instr_mem       instruction memory contents (combinational read)
//   redirect_valid  load redirect_pc as the next fetch address
//   redirect_pc     redirect target
//   dec             decode handshake (instr_out/pc_out/instr_valid/instr_ready)
//   halted          a HALT word has been handed to decode; fetch is stopped
//   issue_count     saturating count of words handed to decode
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                 WORD_W      = 20,
    parameter int                 IDX_W       = 5,
    parameter logic [4:0]         HALT_OPCODE = 5'd31,
    parameter logic [WORD_W-1:0]  RESET_PC    = '0,
    parameter int                 CNT_W       = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [2**IDX_W-1:0][WORD_W-1:0]     instr_mem,
    input  logic                                redirect_valid,
    input  logic [WORD_W-1:0]                   redirect_pc,
    fetch_sequencer_if.master                   dec,
    output logic                                halted,
    output logic [CNT_W-1:0]                    issue_count
);

    localparam int MEM_DEPTH = 2**IDX_W;
    localparam int OPC_W     = 5;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_RUN    = 2'd1;
    localparam logic [1:0] STATE_HALTED = 2'd2;

    // -----------------------------------------------------------------------
    // Memory view. This step copies the packed input bus into one word per
    // entry so that the read index is easy to follow.
    // -----------------------------------------------------------------------
    logic [WORD_W-1:0] memWord [MEM_DEPTH];

    generate
        for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : gMemView
            assign memWord[gi] = instr_mem[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]        stateReg,   stateNext;
    logic [WORD_W-1:0] pcReg,      pcNext;
    logic [WORD_W-1:0] instrReg,   instrNext;
    logic [WORD_W-1:0] pcOutReg,   pcOutNext;
    logic              validReg,   validNext;
    logic              haltedReg,  haltedNext;
    logic [CNT_W-1:0]  countReg,   countNext;

    // The load path is shared by start, redirect and sequential fetch. This
    // block picks only the address; the rest of the load is the same for all.
    logic              doLoad;
    logic [WORD_W-1:0] loadAddr;

    logic              fire;
    logic              heldIsHalt;

    assign fire       = validReg && dec.instr_ready;
    assign heldIsHalt = (instrReg[OPC_W-1:0] == HALT_OPCODE);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext  = stateReg;
        pcNext     = pcReg;
        instrNext  = instrReg;
        pcOutNext  = pcOutReg;
        validNext  = validReg;
        haltedNext = haltedReg;
        doLoad     = 1'b0;
        loadAddr   = pcReg;

        // A handshake counts even when a redirect replaces the word in the
        // same cycle. In IDLE and HALTED, validReg is low, so fire stays low.
        countNext = countReg;
        if (fire && (countReg != {CNT_W{1'b1}})) begin
            countNext = countReg + CNT_W'(1);
        end

        case (stateReg)
            STATE_IDLE: begin
                // A redirect is ignored here. Only start begins fetching.
                if (start) begin
                    doLoad   = 1'b1;
                    loadAddr = RESET_PC;
                end
            end

            STATE_RUN: begin
                if (redirect_valid) begin
                    // This drops a held word that was not accepted this cycle.
                    doLoad   = 1'b1;
                    loadAddr = redirect_pc;
                end else if (fire && heldIsHalt) begin
                    // HALT went downstream. pc stays where it is.
                    validNext  = 1'b0;
                    haltedNext = 1'b1;
                    stateNext  = STATE_HALTED;
                end else if (fire) begin
                    doLoad   = 1'b1;
                    loadAddr = pcReg;
                end
            end

            STATE_HALTED: begin
                // If start and redirect arrive together, start wins.
                if (start) begin
                    doLoad   = 1'b1;
                    loadAddr = RESET_PC;
                end else if (redirect_valid) begin
                    doLoad   = 1'b1;
                    loadAddr = redirect_pc;
                end
            end

            default: begin
                stateNext = STATE_IDLE;
            end
        endcase

        if (doLoad) begin
            // Only the low IDX_W bits select the word, so the memory repeats
            // every 2**IDX_W addresses. The PC itself wraps at 2**WORD_W.
            instrNext  = memWord[loadAddr[IDX_W-1:0]];
            pcOutNext  = loadAddr;
            pcNext     = loadAddr + WORD_W'(1);
            validNext  = 1'b1;
            haltedNext = 1'b0;
            stateNext  = STATE_RUN;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg  <= STATE_IDLE;
            pcReg     <= RESET_PC;
            instrReg  <= '0;
            pcOutReg  <= '0;
            validReg  <= 1'b0;
            haltedReg <= 1'b0;
            countReg  <= '0;
        end else begin
            stateReg  <= stateNext;
            pcReg     <= pcNext;
            instrReg  <= instrNext;
            pcOutReg  <= pcOutNext;
            validReg  <= validNext;
            haltedReg <= haltedNext;
            countReg  <= countNext;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign dec.instr_out   = instrReg;
    assign dec.pc_out      = pcOutReg;
    assign dec.instr_valid = validReg;
    assign halted          = haltedReg;
    assign issue_count     = countReg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Purpose : Self-checking bench for fetch_sequencer. It keeps a rule-level
//           model of the fetch stage and compares the DUT against it on
//           every cycle. Directed steps add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic [31:0][19:0]     mem;
    logic                  redirect_valid;
    logic [19:0]           redirect_pc;
    logic                  halted;
    logic [15:0]           issue_count;

    fetch_sequencer_if #(.WORD_W(20)) dec ();

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .instr_mem      (mem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec),
        .halted         (halted),
        .issue_count    (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Model. Its state is a few flags plus the values the outputs must show.
    // -----------------------------------------------------------------------
    logic        mRunning, mHalted, mValid, chk;
    logic [19:0] mPc, mOut, mPcOut;
    logic [15:0] mCount;

    task automatic mLoad(input logic [19:0] a);
        logic [4:0] idx;
        idx      = a[4:0];
        mOut     = mem[idx];
        mPcOut   = a;
        mPc      = a + 20'd1;
        mValid   = 1'b1;
        mRunning = 1'b1;
        mHalted  = 1'b0;
    endtask

    initial chk = 1'b0;

    always @(posedge clk) begin
        logic fire;
        logic [4:0] opc;
        if (reset) begin
            mRunning = 1'b0; mHalted = 1'b0; mValid = 1'b0;
            mPc = 20'd0; mOut = 20'd0; mPcOut = 20'd0; mCount = 16'd0;
            chk = 1'b1;
        end else if (chk) begin
            fire = mValid && dec.instr_ready;
            opc  = mOut[4:0];
            if (fire && mCount != 16'hFFFF) mCount = mCount + 16'd1;
            if (!mRunning) begin
                if (start) mLoad(20'd0);
                else if (mHalted && redirect_valid) mLoad(redirect_pc);
            end else if (redirect_valid) begin
                mLoad(redirect_pc);
            end else if (fire && opc == 5'd31) begin
                mValid = 1'b0; mHalted = 1'b1; mRunning = 1'b0;
            end else if (fire) begin
                mLoad(mPc);
            end
        end
    end

    // One compare process. It checks every output on every cycle, away from the edge.
    always @(negedge clk) begin
        if (chk) begin
            check("instr_valid", {31'd0, dec.instr_valid}, {31'd0, mValid});
            check("halted",      {31'd0, halted},          {31'd0, mHalted});
            check("issue_count", {16'd0, issue_count},     {16'd0, mCount});
            if (mValid) begin
                check("instr_out", {12'd0, dec.instr_out}, {12'd0, mOut});
                check("pc_out",    {12'd0, dec.pc_out},    {12'd0, mPcOut});
                if (dec.instr_ready)
                    $display("xfer pc=%05h instr=%05h count=%0d", dec.pc_out, dec.instr_out, issue_count);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input logic [19:0] pc, input logic [19:0] ins, input logic v,
                       input logic h, input logic [15:0] cnt);
        check("lit_pc_out",      {12'd0, dec.pc_out},      {12'd0, pc});
        check("lit_instr_out",   {12'd0, dec.instr_out},   {12'd0, ins});
        check("lit_instr_valid", {31'd0, dec.instr_valid}, {31'd0, v});
        check("lit_halted",      {31'd0, halted},          {31'd0, h});
        check("lit_issue_count", {16'd0, issue_count},     {16'd0, cnt});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 20'(i << 5);
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        dec.instr_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        lit(20'd0, 20'd0, 1'b0, 1'b0, 16'd0);

        // 1: sequential fetch at full rate
        start = 1'b1; dec.instr_ready = 1'b1;
        tick(); start = 1'b0;
        lit(20'd0, 20'h00000, 1'b1, 1'b0, 16'd0);
        tick(); lit(20'd1, 20'h00020, 1'b1, 1'b0, 16'd1);
        tick(); lit(20'd2, 20'h00040, 1'b1, 1'b0, 16'd2);
        tick(); lit(20'd3, 20'h00060, 1'b1, 1'b0, 16'd3);

        // 2: backpressure while mem[0] is held
        reset = 1'b1; tick(); reset = 1'b0;
        start = 1'b1; dec.instr_ready = 1'b0;
        tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); lit(20'd0, 20'h00000, 1'b1, 1'b0, 16'd0);
        end
        dec.instr_ready = 1'b1;
        tick(); lit(20'd1, 20'h00020, 1'b1, 1'b0, 16'd1);
        tick(); dec.instr_ready = 1'b0;
        lit(20'd2, 20'h00040, 1'b1, 1'b0, 16'd2);

        // 3: redirect under backpressure
        redirect_valid = 1'b1; redirect_pc = 20'd7;
        tick(); redirect_valid = 1'b0;
        lit(20'd7, 20'h000E0, 1'b1, 1'b0, 16'd2);

        // 4: HALT at mem[3]
        mem[3] = 20'h0001F;
        reset = 1'b1; tick(); reset = 1'b0;
        start = 1'b1; dec.instr_ready = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        lit(20'd3, 20'h0001F, 1'b1, 1'b0, 16'd3);
        tick(); lit(20'd3, 20'h0001F, 1'b0, 1'b1, 16'd4);
        for (int i = 0; i < 10; i++) tick();
        lit(20'd3, 20'h0001F, 1'b0, 1'b1, 16'd4);
        start = 1'b1;
        tick(); start = 1'b0; dec.instr_ready = 1'b0;
        lit(20'd0, 20'h00000, 1'b1, 1'b0, 16'd4);
        // The HALT word stays held under backpressure and does not halt yet.
        dec.instr_ready = 1'b1;
        tick(); tick(); tick(); dec.instr_ready = 1'b0;
        tick(); tick();
        lit(20'd3, 20'h0001F, 1'b1, 1'b0, 16'd7);
        dec.instr_ready = 1'b1;
        tick(); lit(20'd3, 20'h0001F, 1'b0, 1'b1, 16'd8);
        // Start and redirect arrive together in HALTED; start wins.
        start = 1'b1; redirect_valid = 1'b1; redirect_pc = 20'd9;
        tick(); start = 1'b0; redirect_valid = 1'b0;
        lit(20'd0, 20'h00000, 1'b1, 1'b0, 16'd8);
        tick(); tick(); tick(); tick();
        dec.instr_ready = 1'b0;
        lit(20'd3, 20'h0001F, 1'b0, 1'b1, 16'd12);
        // A redirect alone in HALTED restarts fetch.
        redirect_valid = 1'b1; redirect_pc = 20'd9;
        tick(); redirect_valid = 1'b0;
        lit(20'd9, 20'h00120, 1'b1, 1'b0, 16'd12);

        // 5: index and PC wrap
        redirect_valid = 1'b1; redirect_pc = 20'd31;
        tick(); redirect_valid = 1'b0; dec.instr_ready = 1'b1;
        lit(20'd31, 20'h003E0, 1'b1, 1'b0, 16'd12);
        tick(); lit(20'd32, 20'h00000, 1'b1, 1'b0, 16'd13);
        redirect_valid = 1'b1; redirect_pc = 20'hFFFFF;
        tick(); redirect_valid = 1'b0;
        lit(20'hFFFFF, 20'h003E0, 1'b1, 1'b0, 16'd14);
        tick(); lit(20'h00000, 20'h00000, 1'b1, 1'b0, 16'd15);

        // 6: reset mid-stream with start held
        reset = 1'b1; start = 1'b1;
        tick(); reset = 1'b0; start = 1'b0;
        lit(20'd0, 20'd0, 1'b0, 1'b0, 16'd0);
        redirect_valid = 1'b1; redirect_pc = 20'd5;
        tick(); redirect_valid = 1'b0;
        lit(20'd0, 20'd0, 1'b0, 1'b0, 16'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
